// File: rtl/lt24_touch_pio_in.sv
// lt24_touch_pio_in: Avalon-MM input PIO for the LT24 touch-controller status
// lines (BUSY, PENIRQ, spare GPIO).
// Each pin is synchronised and optionally debounced. Edges on the accepted
// level are captured, and an interrupt is raised through a mask.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[1:0]        0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAPTURE (W1C)
//   chipselect, write_n write strobe = chipselect & ~write_n
//   writedata[31:0]     write data, only bits [WIDTH-1:0] are used
//   readdata[31:0]      registered read data, one clock after address
//   in_port[WIDTH-1:0]  asynchronous pin inputs
//   irq                 interrupt request, active high

// Per-pin front end: synchroniser chain plus optional debounce.
module lt24_touch_pio_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_stable
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_stable;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_stable <= 1'b0;
      else          r_stable <= w_sync;
  end else begin : g_debounce
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] r_cnt;

    // The counter holds the number of consecutive clocks that sync has
    // disagreed with stable. On the Nth disagreement the new level is accepted.
    // A single agreeing clock restarts the count.
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (w_sync == r_stable) begin
        r_cnt    <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt    <= '0;
        r_stable <= w_sync;
      end else begin
        r_cnt    <= r_cnt + CW'(1);
      end
  end
endmodule

module lt24_touch_pio_in #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 1,
  parameter int IRQ_LEVEL       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ec;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic [31:0]      r_readdata;
  logic             w_wr;
  logic             w_unused;

  // Data bits above WIDTH are ignored on writes.
  assign w_unused = &{1'b0, writedata};

  lt24_touch_pio_bit #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_bit [WIDTH-1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .i_pin   (in_port),
    .o_stable(w_stable)
  );

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  if (EDGE_TYPE == 0) begin : g_rise
    assign w_edge = w_stable & ~r_stable_d;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign w_edge = ~w_stable & r_stable_d;
  end else begin : g_any
    assign w_edge = w_stable ^ r_stable_d;
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux[WIDTH-1:0] = w_stable;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
      2'd3:    w_rd_mux[WIDTH-1:0] = r_ec;
      default: w_rd_mux = '0;
    endcase
  end

  // Capture is OR-ed in after the clear, so an edge that coincides with a
  // clear of the same bit leaves the bit set.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_stable_d <= '0;
      r_mask     <= '0;
      r_ec       <= '0;
      r_readdata <= '0;
    end else begin
      r_stable_d <= w_stable;
      r_ec       <= (r_ec & ~w_clr) | w_edge;
      r_readdata <= w_rd_mux;
      if (w_wr && address == 2'd2) r_mask <= writedata[WIDTH-1:0];
    end

  assign readdata = r_readdata;

  if (IRQ_LEVEL == 0) begin : g_irq_edge
    assign irq = |(r_ec & r_mask);
  end else begin : g_irq_level
    assign irq = |(w_stable & r_mask);
  end
endmodule
